serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
Parametrised multi-cycle adder/subtractor. It processes DIGIT bits per clock through a chain of full-adder cells and carries the result between cycles in a register. This is the successor to the single-bit combinational full adder, adding a width parameter, subtract mode, overflow flagging and valid/ready handshakes. It is intended for area-constrained datapaths where a WIDTH-bit carry chain per cycle is too costly.

Parameters:
WIDTH, 8, operand and result width in bits (>= 2)
DIGIT, 1, bits processed per cycle; WIDTH % DIGIT != 0 is an elaboration error
STEPS (localparam), WIDTH/DIGIT, number of compute cycles per operation

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands presented
in_ready  output  1  block can accept operands
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in in add mode; borrow-in in sub mode
sub  input  1  0 = A+B+cin, 1 = A-B-cin
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
sum  output  WIDTH  result
cout  output  1  final carry; in sub mode, 1 = no borrow
ovf  output  1  signed two's-complement overflow

Behaviour:
- One clock, clk. rst_n is asynchronous and active-low. Assertion forces state IDLE; clears all operand, result, carry and counter registers; drives out_valid=0, sum=0, cout=0, ovf=0. in_ready = (state==IDLE), so it reads 1 during reset; inputs are ignored while rst_n=0.
- FSM states: IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at an edge: latch a into the A shift register; latch (sub ? ~b : b) into the B shift register; set carry = cin ^ sub; set step counter=0; go to RUN.
- RUN:
  - in_ready=0.
  - Each edge: the DIGIT LSBs of A and B plus the carry register pass through DIGIT chained full-adder cells.
  - The DIGIT sum bits shift into the MSB end of the result register (result shifts right by DIGIT).
  - The carry register takes the chain carry-out. A and B shift right by DIGIT. The counter increments.
  - On the edge where counter==STEPS-1, additionally capture ovf = (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1), and go to DONE.
- DONE:
  - out_valid=1; sum/cout/ovf are held stable.
  - On out_valid&&out_ready at an edge: go to IDLE and drop out_valid. sum/cout/ovf keep their last value until the next result.
- Latency: out_valid first high STEPS cycles after the accepting edge.
  - No overlap between operations: the minimum initiation interval is STEPS+2 cycles.
  - in_valid asserted in RUN or DONE is not accepted.
- Operand or sub changes after acceptance have no effect; all inputs are sampled only at the accept edge.
- Arithmetic is modulo 2^WIDTH. cout is bit WIDTH of the unsigned sum A + (B or ~B) + carry0.
- Reset mid-RUN or mid-DONE aborts the operation: no out_valid pulse, and registers are cleared.
- out_ready held high in IDLE/RUN has no effect.

Decomposition:
- Package adder_pkg holds:
  - state encoding constants S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2;
  - a function clog2 used for the counter width, $clog2(STEPS), minimum 1.
- One sub-module, serial_adder_digit: purely combinational. It contains DIGIT chained fulladd cells and outputs DIGIT sum bits, the carry-out, and the carry into its top cell (used for ovf).
- The FSM, shift registers and counter live in serial_adder.

Test Plan:
1. WIDTH=8, DIGIT=1: a=0x0F, b=0x01, cin=0, sub=0 -> out_valid exactly 8 cycles after accept; sum=0x10, cout=0, ovf=0. Then a=0xFF, b=0x01, cin=1 -> sum=0x01, cout=1, ovf=0.
2. Overflow: a=0x7F, b=0x01, add -> sum=0x80, cout=0, ovf=1. Subtract: a=0x80, b=0x01, sub=1, cin=0 -> sum=0x7F, cout=1, ovf=1. Also a=0x05, b=0x07, sub=1 -> sum=0xFE, cout=0, ovf=0.
3. Backpressure: hold out_ready=0 for 5 cycles in DONE while toggling in_valid and operands -> out_valid stays 1, sum/cout/ovf unchanged, in_ready=0. Release out_ready -> IDLE on the next edge, then accept a new operation.
4. Reset mid-operation: rst_n low asynchronously at step 3 of RUN -> out_valid=0, sum=0 immediately, no result pulse. After release, 0x10+0x20 -> sum=0x30.
5. WIDTH=8, DIGIT=4: latency 2 cycles; exhaustive random 2000 ops with sub/cin randomised and random out_ready stalls -> every result matches the reference model {cout,sum} = a + (sub?~b:b) + (cin^sub) and the signed ovf rule.
6. WIDTH=3, DIGIT=1: exhaustive all 8x8x2x2 combinations -> all match the model. Initiation interval measured as exactly STEPS+2 with out_ready tied high.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared definitions for the serial adder/subtractor.
//   state_e : FSM state encoding (IDLE -> RUN -> DONE -> IDLE)
//   clog2   : counter width helper, never smaller than 1 bit
package adder_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned v = 1; v < n; v = v << 1) begin
      r = r + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/serial_adder_digit.sv
// Combinational slice of DIGIT chained full-adder cells.
//   a_i, b_i  : DIGIT operand bits (LSB first)
//   cin_i     : carry into the lowest cell
//   sum_o     : DIGIT sum bits
//   cout_o    : carry out of the highest cell
//   ctop_o    : carry into the highest cell (needed for signed overflow)
module serial_adder_digit #(
  parameter int unsigned DIGIT = 1
) (
  input  logic [DIGIT-1:0] a_i,
  input  logic [DIGIT-1:0] b_i,
  input  logic             cin_i,
  output logic [DIGIT-1:0] sum_o,
  output logic             cout_o,
  output logic             ctop_o
);

  logic [DIGIT:0] c;

  always_comb begin
    c     = '0;
    sum_o = '0;
    c[0]  = cin_i;
    for (int unsigned i = 0; i < DIGIT; i++) begin
      sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
      c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end
  end

  assign cout_o = c[DIGIT];
  assign ctop_o = c[DIGIT-1];

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor: DIGIT bits per clock, STEPS = WIDTH/DIGIT
// compute cycles per operation, valid/ready handshakes on both sides.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake (in_ready only in IDLE)
//   a, b, cin, sub      : operands; sub=1 computes A-B-cin (cin = borrow-in)
//   out_valid/out_ready : result handshake
//   sum, cout, ovf      : result, final carry (sub: 1 = no borrow), signed overflow
module serial_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned STEPS = WIDTH / DIGIT;
  localparam int unsigned CW    = clog2(STEPS);

  if ((WIDTH % DIGIT) != 0 || WIDTH < 2) begin : g_bad_params
    $error("serial_adder: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  state_e            state_q;
  logic [WIDTH-1:0]  a_q, b_q, res_q, res_d, sum_q;
  logic              carry_q, cout_q, ovf_q, out_valid_q;
  logic [CW-1:0]     cnt_q;

  logic [DIGIT-1:0]  d_sum;
  logic              d_cout, d_ctop;

  serial_adder_digit #(.DIGIT(DIGIT)) u_digit (
    .a_i    (a_q[DIGIT-1:0]),
    .b_i    (b_q[DIGIT-1:0]),
    .cin_i  (carry_q),
    .sum_o  (d_sum),
    .cout_o (d_cout),
    .ctop_o (d_ctop)
  );

  // New digit enters at the MSB end; after STEPS shifts the LSB digit lands at bit 0.
  always_comb begin
    res_d = (res_q >> DIGIT) | (WIDTH'(d_sum) << (WIDTH - DIGIT));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            // Subtraction as A + ~B + ~borrow
            b_q     <= sub ? ~b : b;
            carry_q <= cin ^ sub;
            cnt_q   <= '0;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          a_q     <= a_q >> DIGIT;
          b_q     <= b_q >> DIGIT;
          res_q   <= res_d;
          carry_q <= d_cout;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == CW'(STEPS - 1)) begin
            // Last digit holds bit WIDTH-1, so its top cell gives the MSB carries
            sum_q       <= res_d;
            cout_q      <= d_cout;
            ovf_q       <= d_ctop ^ d_cout;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: three instances (8/1, 8/4, 3/1),
// one shared stimulus bus steered by sel, results against an integer model.
module tb_serial_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, out_ready, cin, sub;
  logic [7:0]  a, b;
  int unsigned sel;

  logic [2:0]  ir, ov, co, of;
  logic [7:0]  s0, s1;
  logic [2:0]  s2;

  logic        o_ir, o_ov, o_co, o_of;
  logic [7:0]  o_sum;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8), .DIGIT(1)) u_w8d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid && sel == 0), .in_ready(ir[0]),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(ov[0]),
    .out_ready(out_ready && sel == 0), .sum(s0), .cout(co[0]), .ovf(of[0]));

  serial_adder #(.WIDTH(8), .DIGIT(4)) u_w8d4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid && sel == 1), .in_ready(ir[1]),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(ov[1]),
    .out_ready(out_ready && sel == 1), .sum(s1), .cout(co[1]), .ovf(of[1]));

  serial_adder #(.WIDTH(3), .DIGIT(1)) u_w3d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid && sel == 2), .in_ready(ir[2]),
    .a(a[2:0]), .b(b[2:0]), .cin(cin), .sub(sub), .out_valid(ov[2]),
    .out_ready(out_ready && sel == 2), .sum(s2), .cout(co[2]), .ovf(of[2]));

  always_comb begin
    o_ir  = 1'b0;
    o_ov  = 1'b0;
    o_co  = 1'b0;
    o_of  = 1'b0;
    o_sum = '0;
    case (sel)
      0: begin o_ir = ir[0]; o_ov = ov[0]; o_co = co[0]; o_of = of[0]; o_sum = s0; end
      1: begin o_ir = ir[1]; o_ov = ov[1]; o_co = co[1]; o_of = of[1]; o_sum = s1; end
      default: begin o_ir = ir[2]; o_ov = ov[2]; o_co = co[2]; o_of = of[2]; o_sum = {5'b0, s2}; end
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (sel=%0d t=%0t)", tag, got, exp, sel, $time);
    end
  endtask

  // Reference: integer arithmetic; overflow = true signed result out of range.
  function automatic logic [9:0] model(input int unsigned w, input logic [7:0] av, input logic [7:0] bv,
                                       input logic ci, input logic su);
    int unsigned mask, x, y, full, s, c;
    int sa, sb, r;
    logic o;
    mask = (1 << w) - 1;
    x    = av & mask;
    y    = bv & mask;
    full = su ? (x + ((~y) & mask) + (ci ? 0 : 1)) : (x + y + ci);
    s    = full & mask;
    c    = (full >> w) & 1;
    sa   = int'(x) - (((x >> (w - 1)) & 1) != 0 ? int'(1 << w) : 0);
    sb   = int'(y) - (((y >> (w - 1)) & 1) != 0 ? int'(1 << w) : 0);
    r    = su ? (sa - sb - int'(ci)) : (sa + sb + int'(ci));
    o    = (r < -(1 <<< (w - 1))) || (r > (1 <<< (w - 1)) - 1);
    return {o, c[0], s[7:0]};
  endfunction

  function automatic int unsigned steps_of(input int unsigned s);
    return (s == 0) ? 8 : (s == 1) ? 2 : 3;
  endfunction

  task automatic do_op(input logic [7:0] av, input logic [7:0] bv, input logic ci, input logic su,
                       input logic [7:0] es, input logic ec, input logic eo, input int stall);
    int k;
    @(negedge clk);
    k = 0;
    while (!o_ir && k < 50) begin @(negedge clk); k++; end
    check("in_ready_idle", 32'(o_ir), 32'd1);
    a = av; b = bv; cin = ci; sub = su; in_valid = 1'b1;
    out_ready = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom); cin = 1'($urandom);
    k = 0;
    while (!o_ov && k < 50) begin @(posedge clk); #1; k++; end
    check("latency", 32'(k), 32'(steps_of(sel)));
    out_ready = 1'b0;
    repeat (stall) begin
      @(negedge clk);
      check("stall_valid", 32'(o_ov), 32'd1);
      check("stall_ready", 32'(o_ir), 32'd0);
      check("stall_sum", 32'(o_sum), 32'(es));
      in_valid = 1'($urandom); a = 8'($urandom); b = 8'($urandom);
    end
    @(negedge clk);
    check("out_valid", 32'(o_ov), 32'd1);
    check("sum", 32'(o_sum), 32'(es));
    check("cout", 32'(o_co), 32'(ec));
    check("ovf", 32'(o_of), 32'(eo));
    out_ready = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    check("drop_valid", 32'(o_ov), 32'd0);
    check("back_idle", 32'(o_ir), 32'd1);
    check("sum_hold", 32'(o_sum), 32'(es));
    out_ready = 1'b0;
  endtask

  typedef struct {
    logic [7:0] a, b;
    logic ci, su;
    logic [7:0] s;
    logic c, o;
  } vec_t;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t dir[$];
    logic [9:0] m;
    int t0, t1, cyc, n, seen;

    sel = 0; rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    cin = 1'b0; sub = 1'b0; a = '0; b = '0;
    #1;
    check("rst_in_ready", 32'(o_ir), 32'd1);
    check("rst_out_valid", 32'(o_ov), 32'd0);
    check("rst_sum", 32'(o_sum), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed cases for WIDTH=8, DIGIT=1; the first one also exercises backpressure.
    dir.push_back('{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0});
    dir.push_back('{8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0});
    dir.push_back('{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1});
    dir.push_back('{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1});
    dir.push_back('{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0});
    foreach (dir[i])
      do_op(dir[i].a, dir[i].b, dir[i].ci, dir[i].su, dir[i].s, dir[i].c, dir[i].o, (i == 0) ? 5 : 0);

    // Reset in the middle of RUN (sum currently holds 0xFE).
    @(negedge clk);
    a = 8'h55; b = 8'h22; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_valid", 32'(o_ov), 32'd0);
    check("abort_sum", 32'(o_sum), 32'd0);
    check("abort_in_ready", 32'(o_ir), 32'd1);
    in_valid = 1'b1;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin @(negedge clk); if (o_ov) seen = 1; end
    check("abort_no_pulse", 32'(seen), 32'd0);
    do_op(8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0, 0);

    // WIDTH=8, DIGIT=4: random operations with random stalls.
    sel = 1;
    for (int i = 0; i < 2000; i++) begin
      logic [7:0] ra, rb;
      logic rc, rs;
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom); rs = 1'($urandom);
      m = model(8, ra, rb, rc, rs);
      do_op(ra, rb, rc, rs, m[7:0], m[8], m[9], int'($urandom_range(0, 3)));
    end

    // WIDTH=3, DIGIT=1: exhaustive.
    sel = 2;
    for (int i = 0; i < 256; i++) begin
      logic [7:0] ea, eb;
      logic [7:0] iv;
      iv = 8'(i);
      ea = {5'b0, iv[2:0]}; eb = {5'b0, iv[5:3]};
      m = model(3, ea, eb, iv[6], iv[7]);
      do_op(ea, eb, iv[6], iv[7], m[7:0], m[8], m[9], 0);
    end

    // Initiation interval with in_valid and out_ready held high.
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; a = 8'd1; b = 8'd2; cin = 1'b0; sub = 1'b0;
    cyc = 0; n = 0; t0 = 0; t1 = 0;
    while (n < 2 && cyc < 40) begin
      if (o_ir) begin
        if (n == 0) t0 = cyc; else t1 = cyc;
        n++;
      end
      @(negedge clk);
      cyc++;
    end
    check("ii_accepts", 32'(n), 32'd2);
    check("ii_cycles", 32'(t1 - t0), 32'(steps_of(2) + 2));
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    out_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
